// File: rtl/programmable_delay_line_pkg.sv
// Shared constants and the delay clamp helper for the programmable delay line.
package delay_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_DELAY  = 16;
    localparam int DLY_W          = $clog2(DEF_MAX_DELAY + 1);
    localparam int PTR_W          = $clog2(DEF_MAX_DELAY);

    // 0 is treated as the minimum delay of one tick; oversize requests saturate.
    function automatic int unsigned clamp_delay(input int unsigned sel,
                                                input int unsigned max_d = DEF_MAX_DELAY);
        if (sel == 0)
            return 1;
        else if (sel > max_d)
            return max_d;
        else
            return sel;
    endfunction

endpackage

// File: rtl/programmable_delay_line_if.sv
// Stream-side signal bundle of the programmable delay line.
interface programmable_delay_line_if
    import delay_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_DELAY  = DEF_MAX_DELAY
);
    localparam int SEL_W = $clog2(MAX_DELAY + 1);

    logic                  en;
    logic                  flush;
    logic [SEL_W-1:0]      delay_sel;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_valid;

    modport master (
        output en, flush, delay_sel, data_in,
        input  data_out, out_valid
    );

    modport slave (
        input  en, flush, delay_sel, data_in,
        output data_out, out_valid
    );

endinterface

// File: rtl/programmable_delay_line_ram.sv
// History storage: one synchronous write port, one combinational read port, no reset.
module delay_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    // Read sees pre-edge contents, so the oldest entry is usable on its overwrite cycle.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/programmable_delay_line.sv
// Run-time programmable delay line: presents the sample taken d enabled ticks earlier.
module programmable_delay_line
    import delay_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_DELAY  = DEF_MAX_DELAY
) (
    input  logic                      clk,
    input  logic                      rst_n,
    programmable_delay_line_if.slave  bus
);
    localparam int SEL_W  = $clog2(MAX_DELAY + 1);
    localparam int ADDR_W = $clog2(MAX_DELAY);

    logic [ADDR_W-1:0]     wr_ptr;
    logic [SEL_W-1:0]      fill;
    logic [SEL_W-1:0]      fill_nxt;
    logic [SEL_W-1:0]      d;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  hist_ok;
    logic                  advance;

    assign advance  = bus.en && !bus.flush;
    assign d        = SEL_W'(clamp_delay(32'(bus.delay_sel), MAX_DELAY));
    assign fill_nxt = (fill == SEL_W'(MAX_DELAY)) ? fill : fill + SEL_W'(1);
    assign hist_ok  = (fill_nxt >= d);
    // wr_ptr - (d-1), computed one bit wider and truncated for the modulo wrap.
    assign rd_addr  = ADDR_W'(SEL_W'(wr_ptr) + SEL_W'(1) - d);

    delay_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_DELAY)
    ) u_ram (
        .clk     (clk),
        .we      (advance),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            fill          <= '0;
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
        end else if (bus.flush) begin
            fill          <= '0;
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
        end else if (bus.en) begin
            wr_ptr        <= wr_ptr + ADDR_W'(1);
            fill          <= fill_nxt;
            bus.out_valid <= hist_ok;
            if (!hist_ok)
                bus.data_out <= '0;
            else if (d == SEL_W'(1))
                bus.data_out <= bus.data_in;
            else
                bus.data_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_programmable_delay_line.sv
// Scoreboard bench: stimulus pushes expected {valid,data}; a monitor pops after each edge.
module tb_programmable_delay_line;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    programmable_delay_line_if #(.DATA_WIDTH(8), .MAX_DELAY(16)) bus ();

    programmable_delay_line #(
        .DATA_WIDTH (8),
        .MAX_DELAY  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [8:0]  exp_q [$];
    string       tag_q [$];
    logic [7:0]  hist  [$];
    int          cnt;
    logic [8:0]  last_exp;
    int          n_cmp = 0;
    int          n_mis = 0;

    // Monitor: one expected entry per clock edge that had stimulus behind it.
    always @(posedge clk) begin
        logic [8:0] e;
        string      t;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_cmp++;
            if ({bus.out_valid, bus.data_out} !== e) begin
                n_mis++;
                $display("FAIL %s: got valid=%b data=%02h, expected valid=%b data=%02h",
                         t, bus.out_valid, bus.data_out, e[8], e[7:0]);
            end
        end
    end

    function automatic int clamp_ref(input logic [4:0] s);
        if (s == 0) return 1;
        if (s > 16) return 16;
        return int'(s);
    endfunction

    task automatic step(input logic e, input logic f, input logic [4:0] s,
                        input logic [7:0] din, input string tag);
        int dd;
        @(negedge clk);
        bus.en        = e;
        bus.flush     = f;
        bus.delay_sel = s;
        bus.data_in   = din;
        dd = clamp_ref(s);
        if (f) begin
            cnt      = 0;
            last_exp = '0;
        end else if (e) begin
            hist.push_back(din);
            if (hist.size() > 64) void'(hist.pop_front());
            cnt++;
            if (cnt >= dd) last_exp = {1'b1, hist[hist.size() - dd]};
            else           last_exp = '0;
        end
        exp_q.push_back(last_exp);
        tag_q.push_back(tag);
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        bus.en    = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bus.en = 1'b0; bus.flush = 1'b0; bus.delay_sel = 5'd1; bus.data_in = 8'h00;
        cnt = 0; last_exp = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // d=1 behaves as a plain register, valid from the first edge
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 5'd1, (i % 2 == 0) ? 8'h01 : 8'h00, "d1_alt");

        // d=4 ramp: invalid for three edges, then 0x10, 0x11, ...
        step(1'b1, 1'b1, 5'd4, 8'hEE, "flush_pre_d4");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5'd4, 8'h10 + 8'(i), "d4_ramp");

        // en gating with d=2: outputs hold, nothing lost or duplicated
        step(1'b1, 1'b1, 5'd2, 8'hEE, "flush_pre_gate");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'd2, 8'h30 + 8'(i), "gate_pre");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd2, 8'hA0 + 8'(i), "gate_hold");
        for (int i = 4; i < 8; i++) step(1'b1, 1'b0, 5'd2, 8'h30 + 8'(i), "gate_resume");

        // delay_sel=0 acts as 1
        step(1'b1, 1'b1, 5'd0, 8'hEE, "flush_pre_sel0");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, 8'h50 + 8'(i), "sel0_as_1");

        // delay_sel=31 clamps to 16; 40 samples cross the pointer wrap twice
        step(1'b0, 1'b1, 5'd31, 8'hEE, "flush_en0");
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 5'd31, 8'h60 + 8'(i), "sel31_wrap");

        // delay change 4 -> 2 at sample 0x20 keeps out_valid and shows 0x1F
        step(1'b1, 1'b1, 5'd4, 8'hEE, "flush_pre_chg");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5'd4, 8'h18 + 8'(i), "chg_d4");
        step(1'b1, 1'b0, 5'd2, 8'h20, "chg_to_d2");
        step(1'b1, 1'b0, 5'd2, 8'h21, "chg_d2_next");

        // flush with en=1, then valid returns after 2 enabled edges
        step(1'b1, 1'b1, 5'd2, 8'h22, "flush_en1");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd2, 8'h23 + 8'(i), "post_flush");

        // async reset mid-stream with d=3
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 5'd3, 8'h70 + 8'(i), "pre_reset");
        idle_inputs();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.data_out !== 8'h00) begin
            n_mis++;
            $display("FAIL async_reset: got valid=%b data=%02h, expected valid=0 data=00",
                     bus.out_valid, bus.data_out);
        end
        cnt = 0;
        last_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 5'd3, 8'h80 + 8'(i), "post_reset");

        idle_inputs();
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
